// File: rtl/aes_gf_pkg.sv
// ----------------------------------------------------------------------------
// aes_gf_pkg
// Shared GF(2^8) helpers and types for the AES InvMixColumns datapath.
//   AES_POLY    : reduction constant applied when xtime shifts out bit 7
//   xtime()     : multiply a byte by x (0x02) modulo x^8+x^4+x^3+x+1
//   gf_byte_t   : one state byte
//   aes_col_t   : one 4-byte column, row 0 in bits [31:24]
//   aes_state_t : full state as 4 columns, element [3] holds column 0 so the
//                 packed vector matches the 128-bit column-major bus layout
//   aes_fsm_e   : controller states
// ----------------------------------------------------------------------------
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]       gf_byte_t;
    typedef logic [31:0]      aes_col_t;
    typedef logic [3:0][31:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    function automatic gf_byte_t xtime(input gf_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns_seq_if.sv
// ----------------------------------------------------------------------------
// aes_inv_mix_columns_seq_if
// Input/output handshake bundle for aes_inv_mix_columns_seq.
//   in_valid/in_ready/in_state    : state offered to the block
//   out_valid/out_ready/out_state : transformed state returned
//   mode (AES_MIXCOL_DUAL_MODE_EN only): 0 = inverse, 1 = forward MixColumns
// master = producer/consumer side, slave = the transform block.
// ----------------------------------------------------------------------------
interface aes_inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef AES_MIXCOL_DUAL_MODE_EN
    logic         mode;
`endif

    modport master (
        output in_valid, in_state, out_ready,
`ifdef AES_MIXCOL_DUAL_MODE_EN
        mode,
`endif
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
`ifdef AES_MIXCOL_DUAL_MODE_EN
        mode,
`endif
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/aes_inv_mix_column.sv
// ----------------------------------------------------------------------------
// aes_inv_mix_column
// Combinational single-column transform. Default: InvMixColumns
// (0E,0B,0D,09). With AES_MIXCOL_DUAL_MODE_EN defined a mode input selects
// forward MixColumns (02,03,01,01) when high.
//   col_in  : input column, row 0 in [31:24]
//   mode    : (macro only) 0 = inverse, 1 = forward
//   col_out : transformed column, same layout
// ----------------------------------------------------------------------------
module aes_inv_mix_column
    import aes_gf_pkg::*;
(
    input  aes_col_t col_in,
`ifdef AES_MIXCOL_DUAL_MODE_EN
    input  logic     mode,
`endif
    output aes_col_t col_out
);
    gf_byte_t s  [4];
    gf_byte_t x2 [4];
    gf_byte_t x4 [4];
    gf_byte_t x8 [4];
    gf_byte_t m9 [4];
    gf_byte_t mb [4];
    gf_byte_t md [4];
    gf_byte_t me [4];
    gf_byte_t res[4];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign s[r]  = col_in[31-8*r -: 8];
        assign x2[r] = xtime(s[r]);
        assign x4[r] = xtime(x2[r]);
        assign x8[r] = xtime(x4[r]);
        // 09 = 8+1, 0B = 8+2+1, 0D = 8+4+1, 0E = 8+4+2
        assign m9[r] = x8[r] ^ s[r];
        assign mb[r] = x8[r] ^ x2[r] ^ s[r];
        assign md[r] = x8[r] ^ x4[r] ^ s[r];
        assign me[r] = x8[r] ^ x4[r] ^ x2[r];

        gf_byte_t inv_b;
        assign inv_b = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
`ifdef AES_MIXCOL_DUAL_MODE_EN
        gf_byte_t fwd_b;
        assign fwd_b = x2[r] ^ x2[(r+1)%4] ^ s[(r+1)%4] ^ s[(r+2)%4] ^ s[(r+3)%4];
        assign res[r] = mode ? fwd_b : inv_b;
`else
        assign res[r] = inv_b;
`endif
    end

    assign col_out = {res[0], res[1], res[2], res[3]};
endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// ----------------------------------------------------------------------------
// aes_inv_mix_columns_seq
// Sequential AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE (1/2/4)
// columns per clock, valid/ready on both sides.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : aes_inv_mix_columns_seq_if.slave (in_*/out_* handshakes)
//   busy     : high while in CALC or DONE
// Optional macro AES_MIXCOL_DUAL_MODE_EN adds bus.mode (1 = forward
// MixColumns), captured with in_state at acceptance.
//
// state   | meaning
// IDLE    | in_ready high, waiting for in_valid
// CALC    | transforming columns cnt..cnt+COLS_PER_CYCLE-1 each clock
// DONE    | out_valid high, result held until out_ready
// ----------------------------------------------------------------------------
module aes_inv_mix_columns_seq
    import aes_gf_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst,
    aes_inv_mix_columns_seq_if.slave bus,
    output logic busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter value of the cycle that writes column 3; step is only applied
    // before that, so the 2-bit counter never wraps inside an operation.
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    aes_fsm_e   state_q, state_d;
    logic [1:0] cnt_q;
    aes_state_t work_q;
    aes_state_t result_q;
    logic       in_ready_c, out_valid_c, busy_c;
    logic       calc_last;
`ifdef AES_MIXCOL_DUAL_MODE_EN
    logic       mode_q;
`endif

    assign calc_last = (cnt_q == LAST_CNT);

    logic [1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t   col_in  [COLS_PER_CYCLE];
    aes_col_t   col_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
        assign col_idx[i] = cnt_q + 2'(i);
        assign col_in[i]  = work_q[2'd3 - col_idx[i]];
        aes_inv_mix_column u_col (
            .col_in  (col_in[i]),
`ifdef AES_MIXCOL_DUAL_MODE_EN
            .mode    (mode_q),
`endif
            .col_out (col_out[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = ST_CALC;
            end
            ST_CALC: begin
                busy_c = 1'b1;
                if (calc_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
`ifdef AES_MIXCOL_DUAL_MODE_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_q <= bus.in_state;
                        cnt_q  <= '0;
`ifdef AES_MIXCOL_DUAL_MODE_EN
                        mode_q <= bus.mode;
`endif
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        result_q[2'd3 - col_idx[i]] <= col_out[i];
                    end
                    if (!calc_last) cnt_q <= cnt_q + CNT_STEP;
                end
                ST_DONE: begin
                    if (bus.out_ready) cnt_q <= '0;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_state = result_q;
    assign busy          = busy_c;
endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
module tb_aes_inv_mix_columns_seq;
    localparam int COLS = 1;
    localparam int LAT  = 4 / COLS;

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V2_EXP = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V4_IN  = 128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d;
    localparam logic [127:0] V4_EXP = 128'h01010101_c6c6c6c6_db135345_f20a225c;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   passes = 0;

    aes_inv_mix_columns_seq_if bus();

    aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(COLS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1B) : (b << 1);
    endfunction

    // Forward MixColumns reference (02,03,01,01), used to build round-trip inputs
    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // Offer one state from IDLE with out_ready high; returns result and
    // clocks from the accepting edge to out_valid (-1 if it never came).
    task automatic push(input logic [127:0] s, output logic [127:0] res, output int lat);
        bus.in_state  = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = bus.out_state;
        if (bus.out_valid !== 1'b1) lat = -1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
`ifdef AES_MIXCOL_DUAL_MODE_EN
        bus.mode = 1'b0;
`endif
        #3;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
        else passes++;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
        else passes++;
        checks++;
        if (bus.out_state !== 128'h0) $display("FAIL reset_out_state got %h exp 0", bus.out_state);
        else passes++;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_inverse_vectors();
        logic [127:0] res;
        int lat;
        push(V1_IN, res, lat);
        checks++;
        if (res !== V1_EXP) $display("FAIL vec1_state got %h exp %h", res, V1_EXP);
        else passes++;
        checks++;
        if (lat !== LAT) $display("FAIL vec1_latency got %0d exp %0d", lat, LAT);
        else passes++;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL vec1_back_idle got in_ready=%b busy=%b exp 1/0", bus.in_ready, busy);
        else passes++;
        push(V2_IN, res, lat);
        checks++;
        if (res !== V2_EXP) $display("FAIL vec2_state got %h exp %h", res, V2_EXP);
        else passes++;
        checks++;
        if (lat !== LAT) $display("FAIL vec2_latency got %0d exp %0d", lat, LAT);
        else passes++;
    endtask

    task automatic test_hold();
        int n;
        bus.in_state  = V1_IN;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL hold_reach_done got out_valid %b exp 1", bus.out_valid);
        else passes++;
        bus.in_valid = 1'b1;
        bus.in_state = V2_IN;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.in_ready, busy, bus.out_state} !== {1'b1, 1'b0, 1'b1, V1_EXP})
                $display("FAIL hold_cycle%0d got v=%b r=%b busy=%b %h exp 1/0/1 %h",
                         i, bus.out_valid, bus.in_ready, busy, bus.out_state, V1_EXP);
            else passes++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b010)
            $display("FAIL hold_release got v=%b r=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy);
        else passes++;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.out_state !== V1_EXP)
            $display("FAIL hold_no_capture got busy=%b %h exp 0 %h", busy, bus.out_state, V1_EXP);
        else passes++;
    endtask

    task automatic test_reset_mid_calc();
        logic [127:0] res;
        int lat;
        bus.in_state  = V2_IN;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL midrst_pre_busy got %b exp 1", busy);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100)
            $display("FAIL midrst_ctrl got r=%b v=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, busy);
        else passes++;
        checks++;
        if (bus.out_state !== 128'h0) $display("FAIL midrst_out_state got %h exp 0", bus.out_state);
        else passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        push(V1_IN, res, lat);
        checks++;
        if (res !== V1_EXP) $display("FAIL midrst_fresh got %h exp %h", res, V1_EXP);
        else passes++;
        checks++;
        if (lat !== LAT) $display("FAIL midrst_latency got %0d exp %0d", lat, LAT);
        else passes++;
    endtask

    task automatic test_zero();
        logic [127:0] res;
        int lat;
        push(128'h0, res, lat);
        checks++;
        if (res !== 128'h0 || lat !== LAT) $display("FAIL zero_state got %h lat %0d exp 0 lat %0d", res, lat, LAT);
        else passes++;
    endtask

    task automatic test_roundtrip();
        logic [127:0] s, f, res;
        int lat;
        for (int i = 0; i < 200; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            f = fwd_state(s);
            push(f, res, lat);
            checks++;
            if (res !== s || lat !== LAT)
                $display("FAIL roundtrip%0d got %h lat %0d exp %h lat %0d", i, res, lat, s, LAT);
            else passes++;
        end
    endtask

`ifdef AES_MIXCOL_DUAL_MODE_EN
    task automatic test_mode();
        logic [127:0] res;
        int lat;
        int n;
        bus.mode = 1'b1;
        push(V1_EXP, res, lat);
        bus.mode = 1'b0;
        checks++;
        if (res !== V1_IN) $display("FAIL mode_fwd got %h exp %h", res, V1_IN);
        else passes++;
        bus.in_state  = V1_EXP;
        bus.mode      = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_state !== V1_IN)
            $display("FAIL mode_toggle got v=%b %h exp 1 %h", bus.out_valid, bus.out_state, V1_IN);
        else passes++;
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        logic [127:0] ins  [4];
        logic [127:0] exps [4];
        logic [127:0] outs [8];
        int acc_cyc [4];
        int n_acc, n_out;
        logic acc_now;
        ins[0] = V1_IN;  exps[0] = V1_EXP;
        ins[1] = V2_IN;  exps[1] = V2_EXP;
        ins[2] = '0;     exps[2] = '0;
        ins[3] = V4_IN;  exps[3] = V4_EXP;
        for (int i = 0; i < 8; i++) outs[i] = 'x;
        for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
        n_acc = 0;
        n_out = 0;
        bus.out_ready = 1'b1;
        bus.in_state  = ins[0];
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            acc_now = bus.in_ready & bus.in_valid;
            tick();
            if (acc_now) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) bus.in_state = ins[n_acc];
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (n_out < 8) outs[n_out] = bus.out_state;
                n_out++;
            end
        end
        checks++;
        if (n_acc !== 4) $display("FAIL b2b_accepts got %0d exp 4", n_acc);
        else passes++;
        checks++;
        if (n_out !== 4) $display("FAIL b2b_outputs got %0d exp 4", n_out);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs[i] !== exps[i]) $display("FAIL b2b_out%0d got %h exp %h", i, outs[i], exps[i]);
            else passes++;
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== LAT + 2)
                $display("FAIL b2b_interval%0d got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT + 2);
            else passes++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_inverse_vectors();
        test_hold();
        test_reset_mid_calc();
        test_zero();
        test_roundtrip();
`ifdef AES_MIXCOL_DUAL_MODE_EN
        test_mode();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
